// File: rtl/ad77xx_spi_master.sv
// Serial master for AD7705/AD7706-class delta-sigma ADCs: register transfers,
// interface sync, hardware reset pulse and DRDY-driven round-robin auto reads.
module ad77xx_spi_master #(
    parameter int CLK_DIV      = 4,
    parameter int NUM_CH       = 2,
    parameter int RST_CYCLES   = 64,
    parameter int DRDY_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_reg,
    input  logic [1:0]  cmd_ch,
    input  logic [23:0] cmd_wdata,
    input  logic        auto_en,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic [1:0]  rsp_ch,
    output logic        rsp_err,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    input  logic        adc_drdy_n,
    output logic        adc_rst_n
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W  = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRDY_TIMEOUT - 1);
    localparam logic [1:0]       CH_LAST  = 2'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SHIFT_CMD, S_WAIT_DRDY,
        S_SHIFT_DATA, S_CS_HOLD, S_DONE, S_RST_PULSE
    } state_t;

    state_t r_state, w_next;

    logic [DIV_W-1:0] r_div;
    logic             r_half;
    logic [5:0]       r_bit, r_len;
    logic [31:0]      r_tx;
    logic [23:0]      r_rx;
    logic             r_rd, r_sync, r_wait, r_auto, r_err, r_drdy_q;
    logic [1:0]       r_ch, r_auto_ch;
    logic [RST_W-1:0] r_rst_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_sclk, r_din, r_cs_n, r_adc_rst_n, r_rsp_valid, r_rsp_err;
    logic [23:0]      r_rsp_data;
    logic [1:0]       r_rsp_ch;

    function automatic logic [5:0] f_len(input logic [2:0] rs);
        case (rs)
            3'd3:       f_len = 6'd16;
            3'd5:       f_len = 6'd0;
            3'd6, 3'd7: f_len = 6'd24;
            default:    f_len = 6'd8;
        endcase
    endfunction

    // Left-align the N-bit payload so it follows the comm byte MSB first.
    function automatic logic [23:0] f_align(input logic [23:0] d, input logic [5:0] n);
        case (n)
            6'd8:    f_align = {d[7:0], 16'hFFFF};
            6'd16:   f_align = {d[15:0], 8'hFF};
            default: f_align = d;
        endcase
    endfunction

    logic        w_idle, w_host, w_auto, w_start, w_rd, w_shifting;
    logic        w_tick, w_mid, w_bit_end, w_last, w_enter, w_bit_start, w_timed_out;
    logic [1:0]  w_op, w_ch;
    logic [2:0]  w_reg;
    logic [5:0]  w_len;
    logic [7:0]  w_cb;

    assign w_idle  = (r_state == S_IDLE);
    assign w_host  = w_idle & cmd_valid;
    assign w_auto  = w_idle & auto_en & ~cmd_valid & ~adc_drdy_n;
    assign w_start = w_host | w_auto;
    assign w_op    = w_host ? cmd_op  : 2'd1;
    assign w_reg   = w_host ? cmd_reg : 3'd3;
    assign w_ch    = w_host ? cmd_ch  : r_auto_ch;
    assign w_rd    = (w_op == 2'd1);
    assign w_len   = f_len(w_reg);
    assign w_cb    = {1'b0, w_reg, w_rd, 1'b0, w_ch};

    assign w_shifting = (r_state == S_SHIFT_CMD) || (r_state == S_SHIFT_DATA);
    assign w_tick     = (r_div == DIV_LAST);
    assign w_mid      = w_shifting & w_tick & ~r_half;
    assign w_bit_end  = w_shifting & w_tick & r_half;
    assign w_last     = (r_bit == 6'd0);
    assign w_timed_out = (r_state == S_WAIT_DRDY) && r_drdy_q && (r_to_cnt == TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_next = (w_op == 2'd3) ? S_RST_PULSE : S_CS_SETUP;
            S_CS_SETUP:  if (w_tick) w_next = r_sync ? S_SHIFT_DATA : S_SHIFT_CMD;
            S_SHIFT_CMD: if (w_bit_end && w_last) begin
                if (r_wait)             w_next = S_WAIT_DRDY;
                else if (r_len == 6'd0) w_next = S_CS_HOLD;
                else                    w_next = S_SHIFT_DATA;
            end
            S_WAIT_DRDY: begin
                if (!r_drdy_q)        w_next = S_SHIFT_DATA;
                else if (w_timed_out) w_next = S_CS_HOLD;
            end
            S_SHIFT_DATA: if (w_bit_end && w_last) w_next = S_CS_HOLD;
            S_CS_HOLD:    if (w_tick) w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            S_RST_PULSE:  if (r_rst_cnt == RST_LAST) w_next = S_DONE;
            default:      w_next = S_IDLE;
        endcase
    end

    assign w_enter     = (w_next != r_state);
    assign w_bit_start = ((w_next == S_SHIFT_CMD) || (w_next == S_SHIFT_DATA)) && (w_enter || w_bit_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;  r_half <= 1'b0;  r_bit <= '0;  r_len <= '0;
            r_tx <= '1;   r_rx <= '0;
            r_rd <= 1'b0; r_sync <= 1'b0;  r_wait <= 1'b0; r_auto <= 1'b0;
            r_err <= 1'b0; r_drdy_q <= 1'b1;
            r_ch <= '0;   r_auto_ch <= '0; r_rst_cnt <= '0; r_to_cnt <= '0;
            r_sclk <= 1'b1; r_din <= 1'b1; r_cs_n <= 1'b1; r_adc_rst_n <= 1'b1;
            r_rsp_valid <= 1'b0; r_rsp_err <= 1'b0; r_rsp_data <= '0; r_rsp_ch <= '0;
        end else begin
            r_drdy_q    <= adc_drdy_n;
            r_rsp_valid <= 1'b0;
            r_div       <= (w_enter || w_tick) ? '0 : r_div + 1'b1;
            r_to_cnt    <= (r_state == S_WAIT_DRDY) ? r_to_cnt + 1'b1 : '0;

            if (w_start) begin
                r_ch   <= w_ch;
                r_auto <= w_auto;
                r_rd   <= w_rd;
                r_sync <= (w_op == 2'd2);
                r_wait <= w_rd && (w_reg == 3'd3);
                r_len  <= (w_op == 2'd2) ? 6'd32 : w_len;
                r_tx   <= (w_op == 2'd2) ? '1 : {w_cb, w_rd ? 24'hFFFFFF : f_align(cmd_wdata, w_len)};
                r_rx   <= '0;
                r_err  <= 1'b0;
                if (w_op == 2'd3) begin
                    r_adc_rst_n <= 1'b0;
                    r_rst_cnt   <= '0;
                end else begin
                    r_cs_n <= 1'b0;
                end
            end

            if (r_state == S_RST_PULSE) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
                if (w_next == S_DONE) r_adc_rst_n <= 1'b1;
            end

            // Falling SCLK launches the next DIN bit; rising SCLK samples DOUT.
            if (w_bit_start) begin
                r_sclk <= 1'b0;
                r_din  <= r_tx[31];
                r_tx   <= {r_tx[30:0], 1'b1};
                r_half <= 1'b0;
                r_bit  <= w_enter ? ((w_next == S_SHIFT_CMD) ? 6'd7 : r_len - 6'd1) : r_bit - 6'd1;
            end else if (w_mid) begin
                r_sclk <= 1'b1;
                r_half <= 1'b1;
                if (r_state == S_SHIFT_DATA) r_rx <= {r_rx[22:0], adc_dout};
            end

            if (w_enter && ((w_next == S_WAIT_DRDY) || (w_next == S_CS_HOLD))) r_din <= 1'b1;
            if (w_timed_out) r_err <= 1'b1;
            if ((r_state == S_CS_HOLD) && w_tick) r_cs_n <= 1'b1;

            if (w_enter && (w_next == S_DONE)) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= (r_rd && !r_err) ? r_rx : '0;
                r_rsp_err   <= r_err;
                r_rsp_ch    <= r_ch;
                if (r_auto) r_auto_ch <= (r_auto_ch == CH_LAST) ? 2'd0 : r_auto_ch + 2'd1;
            end
        end
    end

    assign cmd_ready = w_idle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_ch    = r_rsp_ch;
    assign rsp_err   = r_rsp_err;
    assign adc_sclk  = r_sclk;
    assign adc_din   = r_din;
    assign adc_cs_n  = r_cs_n;
    assign adc_rst_n = r_adc_rst_n;

endmodule

// File: tb/tb_ad77xx_spi_master.sv
// Directed bench for ad77xx_spi_master: vector table of register transfers plus
// hand sequences for hardware reset, auto mode, host priority and reset abort.
module tb_ad77xx_spi_master;
    localparam int CLK_DIV = 4, NUM_CH = 2, RST_CYCLES = 64, DRDY_TIMEOUT = 1000;

    logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, auto_en = 1'b0;
    logic [1:0]  cmd_op = '0, cmd_ch = '0;
    logic [2:0]  cmd_reg = '0;
    logic [23:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, adc_sclk, adc_din, adc_cs_n, adc_rst_n;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_ch;
    logic        adc_dout = 1'b1, adc_drdy_n = 1'b1;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ad77xx_spi_master #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .RST_CYCLES(RST_CYCLES),
                        .DRDY_TIMEOUT(DRDY_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_ch(cmd_ch), .cmd_wdata(cmd_wdata),
        .auto_en(auto_en), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ch(rsp_ch),
        .rsp_err(rsp_err), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n), .adc_drdy_n(adc_drdy_n), .adc_rst_n(adc_rst_n));

    // ADC model and pin monitor: DOUT changes after SCLK falls, DIN captured at SCLK rise.
    logic [23:0] adc_word = '0;
    int          adc_n = 0;
    logic [31:0] cap = '0;
    int          ncap = 0, nfall = 0, cs_cnt = 0, cs_falls = 0, rstlow_cnt = 0, rsp_total = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_rst = 1'b1;

    always @(negedge clk) begin
        if (!adc_cs_n && prev_cs) begin
            nfall = 0; ncap = 0; cap = '0; cs_cnt = 0; cs_falls++;
        end
        if (!adc_cs_n) cs_cnt++;
        if (!adc_cs_n && prev_sclk && !adc_sclk) begin
            if (nfall >= 8 && (nfall - 8) < adc_n) adc_dout = adc_word[adc_n - 1 - (nfall - 8)];
            nfall++;
        end
        if (!adc_cs_n && !prev_sclk && adc_sclk) begin
            cap = {cap[30:0], adc_din};
            ncap++;
        end
        if (!adc_rst_n && prev_rst) rstlow_cnt = 0;
        if (!adc_rst_n) rstlow_cnt++;
        if (rsp_valid) rsp_total++;
        prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_rst = adc_rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rs, input logic [1:0] ch,
                         input logic [23:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 5000) begin @(negedge clk); k++; end
        chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_reg = rs; cmd_ch = ch; cmd_wdata = wd; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid; optionally drops DRDY at cycle drdy_at and probes CS/SCLK at probe.
    task automatic wait_rsp(input int budget, input int drdy_at, input int probe, input bit release_drdy,
                            output logic got, output logic [23:0] d, output logic [1:0] c,
                            output logic e);
        got = 1'b0; d = '0; c = '0; e = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (k == drdy_at) adc_drdy_n = 1'b0;
            if (k == probe) chk("cs_low_sclk_high_in_wait", {30'd0, adc_cs_n, adc_sclk}, 32'd1);
            if (rsp_valid) begin
                got = 1'b1; d = rsp_data; c = rsp_ch; e = rsp_err;
                if (release_drdy) adc_drdy_n = 1'b1;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", budget);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rs;
        logic [1:0]  ch;
        logic [23:0] wd;
        logic [23:0] aw;
        int          an;
        int          drdy_at;
        int          probe;
        logic [23:0] e_data;
        logic [1:0]  e_ch;
        logic        e_err;
        int          e_cs;
        int          e_nb;
        logic [31:0] e_din;
    } vec_t;

    vec_t tv[10];

    initial begin
        logic        got, e;
        logic [23:0] d;
        logic [1:0]  c;
        logic [32:0] m;
        int          base;

        tv[0] = '{2'd0, 3'd1, 2'd0, 24'h000040, 24'h0,      0,  -1,  -1, 24'h0,      2'd0, 1'b0, 136, 16, 32'h1040};
        tv[1] = '{2'd1, 3'd3, 2'd1, 24'h0,      24'hA5C3,   16, 500, 300, 24'h00A5C3, 2'd1, 1'b0, 0,   24, 32'h39FFFF};
        tv[2] = '{2'd1, 3'd6, 2'd0, 24'h0,      24'h123456, 24, -1,  -1, 24'h123456, 2'd0, 1'b0, 264, 32, 32'h68FFFFFF};
        tv[3] = '{2'd0, 3'd5, 2'd0, 24'h0,      24'h0,      0,  -1,  -1, 24'h0,      2'd0, 1'b0, 72,  8,  32'h50};
        tv[4] = '{2'd1, 3'd3, 2'd0, 24'h0,      24'hFFFF,   16, -1,  300, 24'h0,      2'd0, 1'b1, 0,   8,  32'h38};
        tv[5] = '{2'd0, 3'd3, 2'd2, 24'h00BEEF, 24'h0,      0,  -1,  -1, 24'h0,      2'd2, 1'b0, 200, 24, 32'h32BEEF};
        tv[6] = '{2'd0, 3'd7, 2'd3, 24'hA5F00F, 24'h0,      0,  -1,  -1, 24'h0,      2'd3, 1'b0, 264, 32, 32'h73A5F00F};
        tv[7] = '{2'd1, 3'd0, 2'd1, 24'h0,      24'h5A,     8,  -1,  -1, 24'h00005A, 2'd1, 1'b0, 136, 16, 32'h09FF};
        tv[8] = '{2'd0, 3'd2, 2'd0, 24'hFFFF12, 24'h0,      0,  -1,  -1, 24'h0,      2'd0, 1'b0, 136, 16, 32'h2012};
        tv[9] = '{2'd2, 3'd0, 2'd2, 24'h0,      24'h0,      0,  -1,  -1, 24'h0,      2'd2, 1'b0, 264, 32, 32'hFFFFFFFF};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pins_cs_sclk_din_rst_ready", {27'd0, adc_cs_n, adc_sclk, adc_din, adc_rst_n, cmd_ready}, 32'h1F);
        chk("reset_rsp_valid_err", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("reset_rsp_data", {8'd0, rsp_data}, 32'd0);
        chk("reset_rsp_ch", {30'd0, rsp_ch}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            adc_word = tv[i].aw; adc_n = tv[i].an; adc_drdy_n = 1'b1;
            issue(tv[i].op, tv[i].rs, tv[i].ch, tv[i].wd);
            wait_rsp(3000, tv[i].drdy_at, tv[i].probe, 1'b1, got, d, c, e);
            m = (33'd1 << tv[i].e_nb) - 33'd1;
            chk($sformatf("v%0d_rsp_data", i), {8'd0, d}, {8'd0, tv[i].e_data});
            chk($sformatf("v%0d_rsp_ch", i), {30'd0, c}, {30'd0, tv[i].e_ch});
            chk($sformatf("v%0d_rsp_err", i), {31'd0, e}, {31'd0, tv[i].e_err});
            chk($sformatf("v%0d_din_bits", i), ncap, tv[i].e_nb);
            chk($sformatf("v%0d_din_stream", i), cap & m[31:0], tv[i].e_din);
            if (tv[i].e_cs != 0) chk($sformatf("v%0d_cs_low_cycles", i), cs_cnt, tv[i].e_cs);
        end

        // Hardware reset pulse with CS untouched.
        base = cs_falls;
        issue(2'd3, 3'd0, 2'd1, 24'h0);
        wait_rsp(500, -1, -1, 1'b1, got, d, c, e);
        chk("hwrst_low_cycles", rstlow_cnt, RST_CYCLES);
        chk("hwrst_cs_never_low", cs_falls, base);
        chk("hwrst_pin_released_at_rsp", {31'd0, adc_rst_n}, 32'd1);
        chk("hwrst_rsp_data", {8'd0, d}, 32'd0);

        // Auto mode round robin.
        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adc_word = 24'h001000 + 24'(i); adc_n = 16;
            @(negedge clk);
            adc_drdy_n = 1'b0;
            wait_rsp(1000, -1, -1, 1'b1, got, d, c, e);
            chk($sformatf("auto%0d_ch", i), {30'd0, c}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("auto%0d_data", i), {8'd0, d}, 32'h001000 + i);
            repeat (5) @(negedge clk);
        end

        // Host command arriving together with DRDY is served before the auto read.
        adc_word = 24'h002222;
        cmd_op = 2'd0; cmd_reg = 3'd1; cmd_ch = 2'd2; cmd_wdata = 24'h00007E;
        cmd_valid = 1'b1; adc_drdy_n = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(1000, -1, -1, 1'b0, got, d, c, e);
        chk("host_first_ch", {30'd0, c}, 32'd2);
        chk("host_first_din", cap & 32'hFFFF, 32'h127E);
        wait_rsp(1000, -1, -1, 1'b1, got, d, c, e);
        chk("auto_after_host_ch", {30'd0, c}, 32'd1);
        chk("auto_after_host_data", {8'd0, d}, 32'h002222);
        auto_en = 1'b0;
        repeat (5) @(negedge clk);

        // Reset mid-transfer: pins return to idle at once and no response follows.
        issue(2'd0, 3'd7, 2'd3, 24'hABCDEF);
        repeat (60) @(negedge clk);
        chk("abort_cs_low_mid_transfer", {31'd0, adc_cs_n}, 32'd0);
        base = rsp_total;
        rst_n = 1'b0;
        #1;
        chk("abort_pins_idle", {29'd0, adc_cs_n, adc_sclk, adc_din}, 32'h7);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("abort_no_rsp", rsp_total, base);

        adc_n = 0;
        issue(2'd0, 3'd1, 2'd0, 24'h000040);
        wait_rsp(1000, -1, -1, 1'b1, got, d, c, e);
        chk("after_abort_din", cap & 32'hFFFF, 32'h1040);
        chk("after_abort_cs_cycles", cs_cnt, 136);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
